// File: rtl/tick_gen_pkg.sv
// Shared constants for the multi-channel tick generator: output modes and
// default counter / wrap-counter widths.
package tick_gen_pkg;

    localparam logic MODE_PULSE  = 1'b0;
    localparam logic MODE_SQUARE = 1'b1;

    localparam int DIV_W_DEFAULT = 16;
    localparam int WRAP_W        = 8;

endpackage

// File: rtl/tick_channel.sv
// One divider channel: 1..active_div counter, shadowed divisor, pulse/square
// output register and a free-running wrap counter.
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEFAULT,
    parameter int DEFAULT_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              load,
    input  logic [DIV_W-1:0]  div_in,
    input  logic              restart,
    output logic              tick,
    output logic [WRAP_W-1:0] wrap_cnt
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] active_div;
    logic [DIV_W-1:0] pending_div;
    logic             pending_vld;

    logic [DIV_W-1:0] load_div;
    logic             wrap;
    logic             apply_pending;
    logic             tick_on_wrap;
    logic             tick_hold;

    // A zero divisor behaves as 1, so it is normalised once on the way in.
    assign load_div = (div_in == '0) ? DIV_W'(1) : div_in;

    // cnt never exceeds active_div; >= just keeps the compare robust.
    assign wrap = en && (cnt >= active_div);

    // A load in this cycle supersedes the old pending value and must wait for
    // the following wrap, so it blocks application here.
    assign apply_pending = pending_vld && !load && (wrap || !en);

    always_comb begin
        tick_on_wrap = 1'b1;
        tick_hold    = 1'b0;
        case (mode)
            MODE_PULSE: begin
                tick_on_wrap = 1'b1;
                tick_hold    = 1'b0;
            end
            MODE_SQUARE: begin
                tick_on_wrap = ~tick;
                tick_hold    = tick;
            end
            default: begin
                tick_on_wrap = 1'b1;
                tick_hold    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= DIV_W'(1);
            active_div  <= DIV_W'(DEFAULT_DIV);
            pending_div <= DIV_W'(DEFAULT_DIV);
            pending_vld <= 1'b0;
            tick        <= 1'b0;
            wrap_cnt    <= '0;
        end else if (restart) begin
            cnt         <= DIV_W'(1);
            tick        <= 1'b0;
            wrap_cnt    <= '0;
            pending_vld <= 1'b0;
            if (load) begin
                active_div <= load_div;
            end else if (pending_vld) begin
                active_div <= pending_div;
            end
        end else begin
            if (load) begin
                pending_div <= load_div;
                pending_vld <= 1'b1;
            end else if (apply_pending) begin
                active_div  <= pending_div;
                pending_vld <= 1'b0;
            end

            if (!en) begin
                cnt  <= DIV_W'(1);
                tick <= 1'b0;
            end else if (wrap) begin
                cnt      <= DIV_W'(1);
                wrap_cnt <= wrap_cnt + WRAP_W'(1);
                tick     <= tick_on_wrap;
            end else begin
                cnt  <= cnt + DIV_W'(1);
                tick <= tick_hold;
            end
        end
    end

endmodule

// File: rtl/multi_tick_generator.sv
// Programmable multi-channel tick / clock-enable generator; the top level only
// slices the packed divisor and wrap-count buses across the channels.
module multi_tick_generator
    import tick_gen_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = DIV_W_DEFAULT,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        en,
    input  logic [NUM_CH-1:0]        mode,
    input  logic [NUM_CH-1:0]        load,
    input  logic [NUM_CH*DIV_W-1:0]  div_in,
    input  logic                     restart,
    output logic [NUM_CH-1:0]        tick,
    output logic [NUM_CH*WRAP_W-1:0] wrap_cnt
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tick_channel #(
            .DIV_W      (DIV_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en[i]),
            .mode    (mode[i]),
            .load    (load[i]),
            .div_in  (div_in[i*DIV_W +: DIV_W]),
            .restart (restart),
            .tick    (tick[i]),
            .wrap_cnt(wrap_cnt[i*WRAP_W +: WRAP_W])
        );
    end

endmodule

// File: tb/tb_multi_tick_generator.sv
// Directed bench for multi_tick_generator: a per-edge vector table for
// channel 0 timing and divisor reloads, then hand-written corner sequences.
module tb_multi_tick_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en;
    logic [3:0]  mode;
    logic [3:0]  load;
    logic [63:0] div_in;
    logic        restart;
    logic [3:0]  tick;
    logic [31:0] wrap_cnt;

    int passed = 0;
    int total  = 0;

    multi_tick_generator #(
        .NUM_CH     (4),
        .DIV_W      (16),
        .DEFAULT_DIV(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .load    (load),
        .div_in  (div_in),
        .restart (restart),
        .tick    (tick),
        .wrap_cnt(wrap_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  load;
        logic [15:0] div;
        logic [3:0]  exp_tick;
        logic [7:0]  exp_wrap0;
    } vec_t;

    localparam int NVEC = 52;
    vec_t vecs[1:NVEC];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        en      = '0;
        mode    = '0;
        load    = '0;
        div_in  = '0;
        restart = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int tick_edges[9];
        int w;
        int sq_exp[12];
        logic [3:0] exp_t;

        // Channel 0 table: D=4 from reset, load 10 while counting, load 3 on a wrap edge.
        tick_edges = '{4, 8, 12, 16, 26, 36, 46, 49, 52};
        for (int k = 1; k <= NVEC; k++) begin
            vecs[k].en       = (k <= 12) ? 4'hF : 4'h1;
            vecs[k].load     = 4'h0;
            vecs[k].div      = 16'd0;
            vecs[k].exp_tick = 4'h0;
        end
        foreach (tick_edges[j]) begin
            vecs[tick_edges[j]].exp_tick = (tick_edges[j] <= 12) ? 4'hF : 4'h1;
        end
        vecs[14].load = 4'h1;
        vecs[14].div  = 16'd10;
        vecs[36].load = 4'h1;
        vecs[36].div  = 16'd3;
        w = 0;
        for (int k = 1; k <= NVEC; k++) begin
            if (vecs[k].exp_tick[0]) w++;
            vecs[k].exp_wrap0 = 8'(w);
        end

        do_reset();
        check("reset tick", 32'(tick), 32'h0);
        check("reset wrap_cnt", wrap_cnt, 32'h0);

        for (int k = 1; k <= NVEC; k++) begin
            en     = vecs[k].en;
            load   = vecs[k].load;
            div_in = {4{vecs[k].div}};
            step();
            check($sformatf("vec%0d tick", k), 32'(tick), 32'(vecs[k].exp_tick));
            check($sformatf("vec%0d wrap0", k), 32'(wrap_cnt[7:0]), 32'(vecs[k].exp_wrap0));
        end
        load = '0;

        // Channel 1 square mode, divisor 3 loaded while disabled.
        do_reset();
        load = 4'b0010;
        div_in[16 +: 16] = 16'd3;
        step();
        load = '0;
        step();
        check("sq idle tick", 32'(tick), 32'h0);
        en   = 4'b0010;
        mode = 4'b0010;
        sq_exp = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
        for (int e = 0; e < 12; e++) begin
            step();
            check($sformatf("sq edge%0d", e + 1), 32'(tick[1]), 32'(sq_exp[e]));
        end
        check("sq wrap1", 32'(wrap_cnt[15:8]), 32'd4);

        // Divisors 0 and 1 in pulse mode, then disable.
        do_reset();
        load   = 4'b1100;
        div_in = {16'd1, 16'd0, 32'd0};
        step();
        load = '0;
        step();
        en = 4'b1100;
        for (int e = 0; e < 5; e++) begin
            step();
            check($sformatf("div01 edge%0d", e + 1), 32'(tick), 32'h0000000C);
        end
        check("div0 wrap", 32'(wrap_cnt[23:16]), 32'd5);
        en = '0;
        step();
        check("disable tick", 32'(tick), 32'h0);
        step();
        step();
        check("disable wrap frozen", wrap_cnt, 32'h05050000);

        // Restart mid-period with a coincident load of 2 on channel 2.
        do_reset();
        load   = 4'b0011;
        div_in = {32'd0, 16'd7, 16'd5};
        step();
        load = '0;
        step();
        en = 4'b0111;
        for (int e = 0; e < 6; e++) step();
        check("pre-restart wrap", wrap_cnt, 32'h00010001);
        restart = 1'b1;
        load    = 4'b0100;
        div_in[32 +: 16] = 16'd2;
        step();
        restart = 1'b0;
        load    = '0;
        check("restart tick", 32'(tick), 32'h0);
        check("restart wrap", wrap_cnt, 32'h0);
        for (int e = 1; e <= 14; e++) begin
            exp_t = {1'b0, (e % 2 == 0), (e % 7 == 0), (e % 5 == 0)};
            step();
            check($sformatf("realign edge%0d", e), 32'(tick), 32'(exp_t));
        end
        check("realign wrap", wrap_cnt, 32'h00070202);

        // Wrap counter rollover on channel 3 at divisor 1.
        do_reset();
        load = 4'b1000;
        div_in[48 +: 16] = 16'd1;
        step();
        load = '0;
        step();
        en = 4'b1000;
        for (int e = 0; e < 255; e++) step();
        check("wrap 255", 32'(wrap_cnt[31:24]), 32'd255);
        step();
        check("wrap rollover", 32'(wrap_cnt[31:24]), 32'd0);

        // Reset while channel 0 square output is high.
        en   = 4'b1001;
        mode = 4'b0001;
        for (int e = 0; e < 5; e++) step();
        check("square high", 32'(tick[0]), 32'd1);
        rst = 1'b1;
        step();
        check("rst tick", 32'(tick), 32'h0);
        check("rst wrap", wrap_cnt, 32'h0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
